smi_wrr_frame_arbiter_x4: RTL and testbench

Four-way weighted round-robin SMI frame arbiter. It merges four upstream SMI request streams onto one downstream SMI bus, sitting in the same position as the request-side arbiter behind the flit width scalers. Arbitration is frame-atomic: a grant is held from the first flit to the end-of-frame flit. Each requester may send up to a configured number of consecutive frames before the grant rotates. The output is registered, and per-port frame counters are provided for bandwidth monitoring.

---
 rtl/smi_wrr_frame_arbiter_x4.sv | 166 ++++++++++++++++
 tb/tb_smi_wrr_frame_arbiter_x4.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_wrr_frame_arbiter_x4.sv
// smi_wrr_frame_arbiter_x4: four-way weighted round-robin SMI frame arbiter.
// Grants are frame-atomic; the output flit register is drained by downstream Stop.
module smi_wrr_frame_arbiter_x4 #(
  parameter int FlitWidth   = 8,
  parameter int WeightWidth = 4,
  parameter int WeightA     = 1,
  parameter int WeightB     = 1,
  parameter int WeightC     = 1,
  parameter int WeightD     = 1,
  parameter int CountWidth  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    smiReqAInReady,
  input  logic [7:0]              smiReqAInEofc,
  input  logic [FlitWidth*8-1:0]  smiReqAInData,
  output logic                    smiReqAInStop,
  input  logic                    smiReqBInReady,
  input  logic [7:0]              smiReqBInEofc,
  input  logic [FlitWidth*8-1:0]  smiReqBInData,
  output logic                    smiReqBInStop,
  input  logic                    smiReqCInReady,
  input  logic [7:0]              smiReqCInEofc,
  input  logic [FlitWidth*8-1:0]  smiReqCInData,
  output logic                    smiReqCInStop,
  input  logic                    smiReqDInReady,
  input  logic [7:0]              smiReqDInEofc,
  input  logic [FlitWidth*8-1:0]  smiReqDInData,
  output logic                    smiReqDInStop,
  output logic                    smiReqOutReady,
  output logic [7:0]              smiReqOutEofc,
  output logic [FlitWidth*8-1:0]  smiReqOutData,
  input  logic                    smiReqOutStop,
  output logic [1:0]              grantId,
  output logic [CountWidth-1:0]   frameCountA,
  output logic [CountWidth-1:0]   frameCountB,
  output logic [CountWidth-1:0]   frameCountC,
  output logic [CountWidth-1:0]   frameCountD
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                  r_state;
  logic [1:0]              r_ptr;
  logic [1:0]              r_grant;
  logic [WeightWidth-1:0]  r_credit;
  logic [CountWidth-1:0]   r_cnt [4];
  logic                    r_oready;
  logic [7:0]              r_oeofc;
  logic [FlitWidth*8-1:0]  r_odata;

  logic [3:0]              w_rdy;
  logic [7:0]              w_eofc [4];
  logic [FlitWidth*8-1:0]  w_data [4];
  logic [WeightWidth-1:0]  w_cred0 [4];
  logic [1:0]              w_sel;
  logic                    w_any;
  logic                    w_open;
  logic                    w_xfer;
  logic                    w_eof;
  logic [3:0]              w_stop;

  // Weight 0 behaves like 1: credit counts the extra frames after the first.
  function automatic logic [WeightWidth-1:0] f_cred(int w);
    return (w > 1) ? WeightWidth'(w - 1) : '0;
  endfunction

  assign w_cred0[0] = f_cred(WeightA);
  assign w_cred0[1] = f_cred(WeightB);
  assign w_cred0[2] = f_cred(WeightC);
  assign w_cred0[3] = f_cred(WeightD);

  assign w_rdy = {smiReqDInReady, smiReqCInReady,
                  smiReqBInReady, smiReqAInReady};
  assign w_eofc[0] = smiReqAInEofc;
  assign w_eofc[1] = smiReqBInEofc;
  assign w_eofc[2] = smiReqCInEofc;
  assign w_eofc[3] = smiReqDInEofc;
  assign w_data[0] = smiReqAInData;
  assign w_data[1] = smiReqBInData;
  assign w_data[2] = smiReqCInData;
  assign w_data[3] = smiReqDInData;

  // Descending scan so the port closest to r_ptr wins.
  always_comb begin
    w_sel = r_ptr;
    w_any = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (w_rdy[r_ptr + 2'(k)]) begin
        w_sel = r_ptr + 2'(k);
        w_any = 1'b1;
      end
    end
  end

  assign w_open = !(r_oready && smiReqOutStop);
  assign w_xfer = (r_state == XFER) && w_rdy[r_grant] && w_open;
  assign w_eof  = w_xfer && (w_eofc[r_grant] != 8'd0);

  always_comb begin
    w_stop = 4'hF;
    if (r_state == XFER && w_open) w_stop[r_grant] = 1'b0;
  end

  assign smiReqAInStop = w_stop[0];
  assign smiReqBInStop = w_stop[1];
  assign smiReqCInStop = w_stop[2];
  assign smiReqDInStop = w_stop[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_grant  <= '0;
      r_credit <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_any) begin
          r_state  <= XFER;
          r_grant  <= w_sel;
          r_credit <= w_cred0[w_sel];
        end
        XFER: if (w_eof) begin
          if (r_credit != '0) begin
            r_credit <= r_credit - 1'b1;
          end else begin
            r_ptr   <= r_grant + 2'd1;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (w_eof) begin
      r_cnt[r_grant] <= r_cnt[r_grant] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oready <= 1'b0;
      r_oeofc  <= '0;
      r_odata  <= '0;
    end else if (w_xfer) begin
      r_oready <= 1'b1;
      r_oeofc  <= w_eofc[r_grant];
      r_odata  <= w_data[r_grant];
    end else if (!smiReqOutStop) begin
      r_oready <= 1'b0;
    end
  end

  assign smiReqOutReady = r_oready;
  assign smiReqOutEofc  = r_oeofc;
  assign smiReqOutData  = r_odata;
  assign grantId        = r_grant;
  assign frameCountA    = r_cnt[0];
  assign frameCountB    = r_cnt[1];
  assign frameCountC    = r_cnt[2];
  assign frameCountD    = r_cnt[3];

endmodule

// File: tb/tb_smi_wrr_frame_arbiter_x4.sv
// tb_smi_wrr_frame_arbiter_x4: directed bench for the WRR frame arbiter.
// Instance uses WeightA=3, WeightB=0 (treated as 1), C/D=1.
module tb_smi_wrr_frame_arbiter_x4;

  typedef struct {
    logic [7:0]  eofc;
    logic [63:0] data;
    int          cyc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy [4];
  logic [7:0]  eofc_d [4];
  logic [63:0] data_d [4];
  logic        stp [4];
  logic        o_rdy;
  logic [7:0]  o_eofc;
  logic [63:0] o_data;
  logic        o_stop;
  logic [1:0]  gid;
  logic [15:0] fc [4];

  ent_t q [4][$];
  ent_t out_log [$];
  logic in_x [4];
  int   cyc;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  smi_wrr_frame_arbiter_x4 #(
    .WeightA(3), .WeightB(0), .WeightC(1), .WeightD(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .smiReqAInReady(rdy[0]), .smiReqAInEofc(eofc_d[0]),
    .smiReqAInData(data_d[0]), .smiReqAInStop(stp[0]),
    .smiReqBInReady(rdy[1]), .smiReqBInEofc(eofc_d[1]),
    .smiReqBInData(data_d[1]), .smiReqBInStop(stp[1]),
    .smiReqCInReady(rdy[2]), .smiReqCInEofc(eofc_d[2]),
    .smiReqCInData(data_d[2]), .smiReqCInStop(stp[2]),
    .smiReqDInReady(rdy[3]), .smiReqDInEofc(eofc_d[3]),
    .smiReqDInData(data_d[3]), .smiReqDInStop(stp[3]),
    .smiReqOutReady(o_rdy), .smiReqOutEofc(o_eofc),
    .smiReqOutData(o_data), .smiReqOutStop(o_stop),
    .grantId(gid),
    .frameCountA(fc[0]), .frameCountB(fc[1]),
    .frameCountC(fc[2]), .frameCountD(fc[3])
  );

  function automatic logic [63:0] mk(int p, int f, int b);
    return {8'(p), 8'(f), 8'(b), 40'h5A5A5A5A5A};
  endfunction

  function automatic void refresh();
    for (int i = 0; i < 4; i++) begin
      rdy[i] = q[i].size() > 0;
      eofc_d[i] = 8'd0;
      data_d[i] = 64'd0;
      if (rdy[i]) begin
        eofc_d[i] = q[i][0].eofc;
        data_d[i] = q[i][0].data;
      end
    end
  endfunction

  task automatic push_frame(int p, int f, int n, int last);
    ent_t e;
    for (int b = 0; b < n; b++) begin
      e.eofc = (b == n - 1) ? 8'(last) : 8'd0;
      e.data = mk(p, f, b);
      e.cyc  = 0;
      q[p].push_back(e);
    end
  endtask

  task automatic driver_loop();
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        if (in_x[i] && q[i].size() > 0) q[i].delete(0);
      refresh();
    end
  endtask

  task automatic monitor_loop();
    ent_t e;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) in_x[i] = rdy[i] && !stp[i];
      if (o_rdy && !o_stop) begin
        e.eofc = o_eofc;
        e.data = o_data;
        e.cyc  = cyc;
        out_log.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (o_rdy !== 1'b0 || o_eofc !== 8'd0 || o_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_out: rdy=%b eofc=%0d data=%h, want 0", o_rdy, o_eofc, o_data);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (stp[i] !== 1'b1 || fc[i] !== 16'd0) begin
        errors++;
        $display("FAIL reset_port%0d: stop=%b count=%0d, want 1/0", i, stp[i], fc[i]);
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gid !== 2'd0 || o_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: grant=%0d rdy=%b, want 0/0", gid, o_rdy);
    end
  endtask

  task automatic test_single();
    int k;
    int ee [3];
    ee = '{0, 0, 8};
    out_log.delete();
    @(posedge clk);
    k = cyc;
    push_frame(1, 0, 3, 8);
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if (out_log.size() !== 3) begin
      errors++;
      $display("FAIL single_count: got %0d flits, want 3", out_log.size());
    end
    for (int j = 0; j < 3 && j < out_log.size(); j++) begin
      checks++;
      if (out_log[j].cyc !== k + 3 + j || out_log[j].eofc !== 8'(ee[j])
          || out_log[j].data !== mk(1, 0, j)) begin
        errors++;
        $display("FAIL single_flit%0d: cyc=%0d eofc=%0d data=%h, want cyc=%0d eofc=%0d data=%h",
                 j, out_log[j].cyc, out_log[j].eofc, out_log[j].data,
                 k + 3 + j, ee[j], mk(1, 0, j));
      end
    end
    checks++;
    if (gid !== 2'd1 || fc[1] !== 16'd1 || o_rdy !== 1'b0) begin
      errors++;
      $display("FAIL single_state: grant=%0d countB=%0d rdy=%b, want 1/1/0", gid, fc[1], o_rdy);
    end
  endtask

  task automatic test_weighting();
    int k, ec;
    int ep [8];
    int ef [8];
    int eg [8];
    ep = '{0, 0, 0, 1, 0, 0, 0, 1};
    ef = '{0, 1, 2, 0, 3, 4, 5, 1};
    eg = '{0, 1, 1, 2, 2, 1, 1, 2};
    out_log.delete();
    @(posedge clk);
    k = cyc;
    for (int f = 0; f < 6; f++) push_frame(0, f, 1, 8);
    for (int f = 0; f < 2; f++) push_frame(1, f, 1, 4);
    repeat (25) @(negedge clk);
    #1;
    checks++;
    if (out_log.size() !== 8) begin
      errors++;
      $display("FAIL weight_count: got %0d frames, want 8", out_log.size());
    end
    ec = k + 3;
    for (int j = 0; j < 8 && j < out_log.size(); j++) begin
      ec = (j == 0) ? ec : ec + eg[j];
      checks++;
      if (out_log[j].data !== mk(ep[j], ef[j], 0) || out_log[j].cyc !== ec) begin
        errors++;
        $display("FAIL weight_frame%0d: data=%h cyc=%0d, want data=%h cyc=%0d",
                 j, out_log[j].data, out_log[j].cyc, mk(ep[j], ef[j], 0), ec);
      end
    end
    checks++;
    if (fc[0] !== 16'd6 || fc[1] !== 16'd3) begin
      errors++;
      $display("FAIL weight_counts: A=%0d B=%0d, want 6/3", fc[0], fc[1]);
    end
  endtask

  task automatic test_back_to_back();
    int k, ec, j;
    int ep [8];
    int ef [8];
    int ng [8];
    ep = '{2, 3, 0, 0, 0, 1, 2, 3};
    ef = '{0, 0, 0, 1, 2, 0, 1, 1};
    ng = '{1, 1, 1, 0, 0, 1, 1, 1};
    out_log.delete();
    @(posedge clk);
    k = cyc;
    for (int f = 0; f < 2; f++) push_frame(2, f, 2, 5);
    for (int f = 0; f < 2; f++) push_frame(3, f, 2, 5);
    for (int f = 0; f < 3; f++) push_frame(0, f, 2, 5);
    push_frame(1, 0, 2, 5);
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (out_log.size() !== 16) begin
      errors++;
      $display("FAIL contend_count: got %0d flits, want 16", out_log.size());
    end
    ec = k + 3;
    for (int f = 0; f < 8; f++) begin
      for (int b = 0; b < 2; b++) begin
        j = 2 * f + b;
        if (j > 0) ec = ec + ((b == 0 && ng[f] == 1) ? 2 : 1);
        if (j < out_log.size()) begin
          checks++;
          if (out_log[j].data !== mk(ep[f], ef[f], b) || out_log[j].cyc !== ec
              || out_log[j].eofc !== ((b == 1) ? 8'd5 : 8'd0)) begin
            errors++;
            $display("FAIL contend_flit%0d: data=%h cyc=%0d eofc=%0d, want data=%h cyc=%0d",
                     j, out_log[j].data, out_log[j].cyc, out_log[j].eofc,
                     mk(ep[f], ef[f], b), ec);
          end
        end
      end
    end
    checks++;
    if (fc[0] !== 16'd9 || fc[1] !== 16'd4 || fc[2] !== 16'd2 || fc[3] !== 16'd2) begin
      errors++;
      $display("FAIL contend_counts: %0d %0d %0d %0d, want 9 4 2 2", fc[0], fc[1], fc[2], fc[3]);
    end
  endtask

  task automatic test_backpressure();
    out_log.delete();
    @(posedge clk);
    push_frame(1, 0, 4, 3);
    for (int n = 0; n < 30 && out_log.size() < 2; n++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (out_log.size() < 2) begin
      errors++;
      $display("FAIL bp_timeout: got %0d flits, want 2", out_log.size());
    end
    @(posedge clk);
    #2 o_stop = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (o_rdy !== 1'b1 || o_data !== mk(1, 0, 2) || o_eofc !== 8'd0 || stp[1] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: rdy=%b data=%h eofc=%0d stopB=%b, want 1/%h/0/1",
                 o_rdy, o_data, o_eofc, stp[1], mk(1, 0, 2));
      end
    end
    @(posedge clk);
    #2 o_stop = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (out_log.size() !== 4) begin
      errors++;
      $display("FAIL bp_count: got %0d flits, want 4", out_log.size());
    end
    for (int j = 0; j < 4 && j < out_log.size(); j++) begin
      checks++;
      if (out_log[j].data !== mk(1, 0, j) || out_log[j].eofc !== ((j == 3) ? 8'd3 : 8'd0)) begin
        errors++;
        $display("FAIL bp_flit%0d: data=%h eofc=%0d, want %h", j, out_log[j].data,
                 out_log[j].eofc, mk(1, 0, j));
      end
    end
    checks++;
    if (fc[1] !== 16'd5) begin
      errors++;
      $display("FAIL bp_countB: got %0d, want 5", fc[1]);
    end
  endtask

  task automatic test_pointer_wrap();
    int ep [4];
    int ef [4];
    ep = '{3, 0, 0, 0};
    ef = '{0, 0, 1, 2};
    @(posedge clk);
    push_frame(2, 5, 1, 1);
    repeat (8) @(negedge clk);
    checks++;
    if (fc[2] !== 16'd3) begin
      errors++;
      $display("FAIL wrap_countC: got %0d, want 3", fc[2]);
    end
    out_log.delete();
    @(posedge clk);
    push_frame(3, 0, 1, 8);
    for (int f = 0; f < 3; f++) push_frame(0, f, 1, 8);
    repeat (15) @(negedge clk);
    #1;
    checks++;
    if (out_log.size() !== 4) begin
      errors++;
      $display("FAIL wrap_count: got %0d frames, want 4", out_log.size());
    end
    for (int j = 0; j < 4 && j < out_log.size(); j++) begin
      checks++;
      if (out_log[j].data !== mk(ep[j], ef[j], 0)) begin
        errors++;
        $display("FAIL wrap_order%0d: data=%h, want %h", j, out_log[j].data, mk(ep[j], ef[j], 0));
      end
    end
    out_log.delete();
    @(posedge clk);
    push_frame(3, 1, 1, 8);
    push_frame(1, 1, 1, 8);
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if (out_log.size() !== 2 || out_log[0].data !== mk(1, 1, 0)
        || out_log[1].data !== mk(3, 1, 0)) begin
      errors++;
      $display("FAIL wrap_ptr0: %0d frames, first=%h, want B first %h",
               out_log.size(), (out_log.size() > 0) ? out_log[0].data : 64'd0, mk(1, 1, 0));
    end
    checks++;
    if (gid !== 2'd3 || fc[0] !== 16'd12) begin
      errors++;
      $display("FAIL wrap_state: grant=%0d countA=%0d, want 3/12", gid, fc[0]);
    end
  endtask

  task automatic test_reset_midframe();
    int k;
    logic hit;
    hit = 1'b0;
    @(posedge clk);
    push_frame(2, 1, 4, 2);
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge clk);
      #1;
      hit = in_x[2] && data_d[2] === mk(2, 1, 1);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rstmid_timeout: flit 2 of C never transferred");
    end
    rst_n = 1'b0;
    q[2].delete();
    #1;
    checks++;
    if (o_rdy !== 1'b0 || o_eofc !== 8'd0 || o_data !== 64'd0 || gid !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_out: rdy=%b eofc=%0d data=%h grant=%0d, want 0",
               o_rdy, o_eofc, o_data, gid);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fc[i] !== 16'd0 || stp[i] !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_port%0d: count=%0d stop=%b, want 0/1", i, fc[i], stp[i]);
      end
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    out_log.delete();
    @(posedge clk);
    k = cyc;
    push_frame(0, 0, 2, 7);
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (out_log.size() !== 2) begin
      errors++;
      $display("FAIL rstmid_count: got %0d flits, want 2", out_log.size());
    end
    for (int j = 0; j < 2 && j < out_log.size(); j++) begin
      checks++;
      if (out_log[j].cyc !== k + 3 + j || out_log[j].data !== mk(0, 0, j)
          || out_log[j].eofc !== ((j == 1) ? 8'd7 : 8'd0)) begin
        errors++;
        $display("FAIL rstmid_flit%0d: cyc=%0d data=%h, want cyc=%0d data=%h",
                 j, out_log[j].cyc, out_log[j].data, k + 3 + j, mk(0, 0, j));
      end
    end
    checks++;
    if (gid !== 2'd0 || fc[0] !== 16'd1 || fc[2] !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_after: grant=%0d A=%0d C=%0d, want 0/1/0", gid, fc[0], fc[2]);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    o_stop = 1'b0;
    cyc    = 0;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4; i++) in_x[i] = 1'b0;
    refresh();
    fork
      driver_loop();
      monitor_loop();
    join_none
    test_reset();
    test_single();
    test_weighting();
    test_back_to_back();
    test_backpressure();
    test_pointer_wrap();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
